// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one async-FIFO write port.
// Revision    : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     wfull,
  output logic                     winc,
  output logic [WIDTH-1:0]         wdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  logic [IW-1:0]      last;
  logic [CW-1:0]      burst_cnt;
  logic               own_req;
  logic               xfer;
  logic               burst_done;
  logic               release_own;
  logic [NUM_REQ-1:0] arb_req;
  logic               pick_vld;
  logic [IW-1:0]      pick;

  // While BUSY, last always equals the current owner's index.
  assign own_req     = req[last];
  assign xfer        = !rst && (state == BUSY) && own_req && !wfull;
  assign burst_done  = (burst_cnt == CW'(MAX_BURST - 1));
  assign release_own = (state == BUSY) && (!own_req || (xfer && burst_done));
  assign arb_req     = (state == BUSY) ? (req & ~gnt) : req;

  assign req_ack = xfer ? gnt : '0;
  assign winc    = xfer;
  assign wdata   = (!rst && (state == BUSY)) ? req_data[int'(last)*WIDTH +: WIDTH] : '0;

  // Scan farthest-first so the nearest requester after last overwrites the result.
  always_comb begin
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick     = last;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (arb_req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      burst_cnt <= '0;
      last      <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            last      <= pick;
            burst_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_own) begin
            burst_cnt <= '0;
            if (pick_vld) begin
              gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
              last  <= pick;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed vector table plus burst/stall sequences.
// Revision    : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  gnt;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;

  fifo_wr_arbiter #(
    .WIDTH    (WIDTH),
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .req_ack (req_ack),
    .gnt     (gnt),
    .wfull   (wfull),
    .winc    (winc),
    .wdata   (wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       wf;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       winc;
    logic [7:0] wdata;
  } vec_t;

  vec_t       tbl[16];
  int         vecs = 0;
  int         miss = 0;
  logic [7:0] d[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1ns later, well before posedge.
  task automatic drive(input logic r, input logic [3:0] rq, input logic wf);
    @(negedge clk);
    rst      = r;
    req      = rq;
    wfull    = wf;
    req_data = {d[3], d[2], d[1], d[0]};
    #1;
  endtask

  task automatic consume();
    for (int i = 0; i < 4; i++)
      if (req_ack[i]) d[i] = d[i] + 8'd1;
  endtask

  initial begin
    int         cnt[4];
    int         owner;
    logic [7:0] exp_d;
    logic       exp_w;
    int         acks;
    logic [8:0] wf_pat;

    // rst, req, wf | gnt, ack, winc, wdata  (data fixed: r0=10 r1=20 r2=30 r3=40)
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10};
    tbl[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'h10};
    tbl[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10};
    tbl[9]  = '{1'b0, 4'b0010, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h10};
    tbl[10] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h20};
    tbl[11] = '{1'b0, 4'b0100, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h20};
    tbl[12] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'h30};
    tbl[13] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10};

    d[0] = 8'h10; d[1] = 8'h20; d[2] = 8'h30; d[3] = 8'h40;
    rst = 1'b1; req = '0; wfull = 1'b0; req_data = '0;
    @(posedge clk);

    for (int v = 0; v < 16; v++) begin
      drive(tbl[v].rst, tbl[v].req, tbl[v].wf);
      chk($sformatf("tbl%0d gnt", v),   32'(gnt),     32'(tbl[v].gnt));
      chk($sformatf("tbl%0d ack", v),   32'(req_ack), 32'(tbl[v].ack));
      chk($sformatf("tbl%0d winc", v),  32'(winc),    32'(tbl[v].winc));
      chk($sformatf("tbl%0d wdata", v), 32'(wdata),   32'(tbl[v].wdata));
    end

    // Lone requester: 4-word bursts separated by a one-cycle gap, data in order.
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    chk("rst2 gnt", 32'(gnt), 32'h0);
    chk("rst2 winc", 32'(winc), 32'h0);
    d[0] = 8'h10;
    exp_d = 8'h10;
    for (int c = 0; c < 11; c++) begin
      drive(1'b0, 4'b0001, 1'b0);
      exp_w = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
      chk($sformatf("lone c%0d winc", c), 32'(winc), 32'(exp_w));
      chk($sformatf("lone c%0d gnt", c), 32'(gnt), exp_w ? 32'h1 : 32'h0);
      if (exp_w) begin
        chk($sformatf("lone c%0d wdata", c), 32'(wdata), 32'(exp_d));
        exp_d = exp_d + 8'd1;
      end
      consume();
    end

    // All requesting: back-to-back bursts 0,1,2,3,0 with no idle cycle.
    drive(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d[i]   = 8'((i + 1) << 4);
      cnt[i] = 0;
    end
    drive(1'b0, 4'b1111, 1'b0);
    chk("all arb gnt", 32'(gnt), 32'h0);
    consume();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 4'b1111, 1'b0);
      owner = ((k - 1) / 4) % 4;
      chk($sformatf("all k%0d gnt", k), 32'(gnt), 32'(1 << owner));
      chk($sformatf("all k%0d ack", k), 32'(req_ack), 32'(1 << owner));
      chk($sformatf("all k%0d wdata", k), 32'(wdata), 32'(((owner + 1) << 4) + cnt[owner]));
      cnt[owner]++;
      consume();
    end

    // Owner 2 stalled by wfull for 3 cycles mid-burst; count stays frozen.
    drive(1'b1, 4'b0000, 1'b0);
    d[2]   = 8'h30;
    exp_d  = 8'h30;
    acks   = 0;
    wf_pat = 9'b000111000;  // bit c = wfull in cycle c
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 4'b0100, wf_pat[c]);
      exp_w = (c >= 1) && (c <= 7) && !wf_pat[c];
      chk($sformatf("stall c%0d winc", c), 32'(winc), 32'(exp_w));
      chk($sformatf("stall c%0d gnt", c), 32'(gnt),
          ((c >= 1) && (c <= 7)) ? 32'h4 : 32'h0);
      if (exp_w) begin
        chk($sformatf("stall c%0d wdata", c), 32'(wdata), 32'(exp_d));
        exp_d = exp_d + 8'd1;
      end
      if (req_ack[2]) acks++;
      consume();
    end
    chk("stall acks", 32'(acks), 32'd4);

    rst = 1'b1;
    req = '0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
`default_nettype wire
